// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants for the ALU control unit and its
// multiply/divide sequencer (operation codes, funct codes, alu_op codes,
// sequencer state encoding).
package alu_ctrl_pkg;

  // ALU operation codes (4-bit base encoding, zero-extended by users)
  localparam logic [3:0] OPC_AND     = 4'b0000;
  localparam logic [3:0] OPC_OR      = 4'b0001;
  localparam logic [3:0] OPC_SLL     = 4'b0010;
  localparam logic [3:0] OPC_ADD     = 4'b0011;
  localparam logic [3:0] OPC_SUB     = 4'b0100;
  localparam logic [3:0] OPC_SRL     = 4'b0101;
  localparam logic [3:0] OPC_LUI     = 4'b0110;
  localparam logic [3:0] OPC_SLT     = 4'b0111;
  localparam logic [3:0] OPC_MULT    = 4'b1000;
  localparam logic [3:0] OPC_DEFAULT = 4'b1001;
  localparam logic [3:0] OPC_DIV     = 4'b1010;
  localparam logic [3:0] OPC_MFHI    = 4'b1011;
  localparam logic [3:0] OPC_MFLO    = 4'b1100;

  // R-type funct field values
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // alu_op values from the main control unit
  localparam logic [2:0] AOP_ORI   = 3'b001;
  localparam logic [2:0] AOP_LUI   = 3'b010;
  localparam logic [2:0] AOP_ANDI  = 3'b011;
  localparam logic [2:0] AOP_ADDI  = 3'b100;
  localparam logic [2:0] AOP_SLTI  = 3'b101;
  localparam logic [2:0] AOP_RTYPE = 3'b111;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// alu_control_seq_if: decode-stage request from the main control unit and
// the ALU / multiply-divide control outputs returned to the datapath.
interface alu_control_seq_if #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int OPER_WIDTH   = 4
);
  logic                    valid_i;
  logic [ALU_OP_WIDTH-1:0] alu_op_i;
  logic [FUNCT_WIDTH-1:0]  alu_function_i;
  logic [OPER_WIDTH-1:0]   alu_operation_o;
  logic                    illegal_o;
  logic                    md_start_o;
  logic                    md_op_o;
  logic                    stall_o;
  logic                    hilo_we_o;

  // Control-unit / datapath side
  modport master (
    output valid_i, alu_op_i, alu_function_i,
    input  alu_operation_o, illegal_o, md_start_o, md_op_o, stall_o, hilo_we_o
  );

  // ALU control unit side
  modport slave (
    input  valid_i, alu_op_i, alu_function_i,
    output alu_operation_o, illegal_o, md_start_o, md_op_o, stall_o, hilo_we_o
  );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: purely combinational selector {alu_op, funct} -> operation
// code plus class flags for the sequencer.
// Optional feature macro: ALU_CTRL_DIV_EN (DIV decoded and flagged; when
// undefined funct 0x1A falls to the default/illegal entry).
module alu_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int OPER_WIDTH   = 4
) (
  input  logic                    valid,
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  output logic [OPER_WIDTH-1:0]   operation,
  output logic                    illegal,
  output logic                    is_md,
  output logic                    is_div,
  output logic                    is_mf
);

  logic [3:0] code;
  logic       hit;

  // Table lookup: R-type entries use funct, I-type entries ignore it
  always_comb begin
    code   = OPC_DEFAULT;
    hit    = 1'b0;
    is_md  = 1'b0;
    is_div = 1'b0;
    is_mf  = 1'b0;
    if (alu_op == ALU_OP_WIDTH'(AOP_RTYPE)) begin
      case (funct)
        FUNCT_WIDTH'(FN_ADD):  begin code = OPC_ADD;  hit = 1'b1; end
        FUNCT_WIDTH'(FN_SUB):  begin code = OPC_SUB;  hit = 1'b1; end
        FUNCT_WIDTH'(FN_AND):  begin code = OPC_AND;  hit = 1'b1; end
        FUNCT_WIDTH'(FN_OR):   begin code = OPC_OR;   hit = 1'b1; end
        FUNCT_WIDTH'(FN_SLT):  begin code = OPC_SLT;  hit = 1'b1; end
        FUNCT_WIDTH'(FN_SLL):  begin code = OPC_SLL;  hit = 1'b1; end
        FUNCT_WIDTH'(FN_SRL):  begin code = OPC_SRL;  hit = 1'b1; end
        FUNCT_WIDTH'(FN_MULT): begin code = OPC_MULT; hit = 1'b1; is_md = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
        FUNCT_WIDTH'(FN_DIV):  begin code = OPC_DIV;  hit = 1'b1; is_md = 1'b1; is_div = 1'b1; end
`endif
        FUNCT_WIDTH'(FN_MFHI): begin code = OPC_MFHI; hit = 1'b1; is_mf = 1'b1; end
        FUNCT_WIDTH'(FN_MFLO): begin code = OPC_MFLO; hit = 1'b1; is_mf = 1'b1; end
        default: ;
      endcase
    end else begin
      case (alu_op)
        ALU_OP_WIDTH'(AOP_ADDI): begin code = OPC_ADD; hit = 1'b1; end
        ALU_OP_WIDTH'(AOP_ORI):  begin code = OPC_OR;  hit = 1'b1; end
        ALU_OP_WIDTH'(AOP_LUI):  begin code = OPC_LUI; hit = 1'b1; end
        ALU_OP_WIDTH'(AOP_ANDI): begin code = OPC_AND; hit = 1'b1; end
        ALU_OP_WIDTH'(AOP_SLTI): begin code = OPC_SLT; hit = 1'b1; end
        default: ;
      endcase
    end
  end

  assign operation = OPER_WIDTH'(code);
  assign illegal   = valid & ~hit;

endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: ALU control decode plus a small sequencer that issues
// multi-cycle MULT/DIV, stalls dependent instructions and pulses the HI/LO
// write enable when the operation completes.
// Optional feature macro: ALU_CTRL_DIV_EN (DIV sequenced with DIV_CYCLES).
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_OP_WIDTH = 3,
  parameter int FUNCT_WIDTH  = 6,
  parameter int OPER_WIDTH   = 4,
  parameter int MULT_CYCLES  = 4,
  parameter int DIV_CYCLES   = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_control_seq_if.slave  bus
);

`ifdef ALU_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // The counter only ever holds CYCLES-1, so clog2 of the longest op fits it
  localparam int MD_MAX    = DIV_EN ? max_int(MULT_CYCLES, DIV_CYCLES) : MULT_CYCLES;
  localparam int CNT_W     = max_int(1, $clog2(MD_MAX));
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(max_int(MULT_CYCLES, 1) - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(max_int(DIV_CYCLES, 1) - 1);

  logic             is_md;
  logic             is_div;
  logic             is_mf;
  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             md_op_reg, md_op_next;
  logic             start;
  logic             hilo;

  alu_decode #(
    .ALU_OP_WIDTH (ALU_OP_WIDTH),
    .FUNCT_WIDTH  (FUNCT_WIDTH),
    .OPER_WIDTH   (OPER_WIDTH)
  ) u_decode (
    .valid     (bus.valid_i),
    .alu_op    (bus.alu_op_i),
    .funct     (bus.alu_function_i),
    .operation (bus.alu_operation_o),
    .illegal   (bus.illegal_o),
    .is_md     (is_md),
    .is_div    (is_div),
    .is_mf     (is_mf)
  );

  // Sequencer next-state: accept in IDLE, count down in BUSY, pulse in DONE
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    md_op_next = md_op_reg;
    start      = 1'b0;
    hilo       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.valid_i && is_md) begin
          start      = 1'b1;
          md_op_next = is_div;
          cnt_next   = (DIV_EN && is_div) ? DIV_LOAD : MULT_LOAD;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DONE: begin
        hilo       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sequencer state, counter and latched operation type
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      md_op_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      md_op_reg <= md_op_next;
    end
  end

  // Handshake outputs are forced quiet while reset is held; md_op shows the
  // new operation type already in the accept cycle.
  assign bus.md_start_o = start & ~reset;
  assign bus.hilo_we_o  = hilo & ~reset;
  assign bus.md_op_o    = md_op_next & ~reset;
  assign bus.stall_o    = ~reset & (state_reg != ST_IDLE) & bus.valid_i & (is_md | is_mf);

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised ALU control unit for the single-cycle MIPS datapath. It combinationally decodes `{alu_op_i, alu_function_i}` into an ALU operation code. It also owns a small sequencer that issues and tracks multi-cycle multiply/divide operations, stalls dependent instructions, and pulses the HI/LO write enable on completion. It sits between the main control unit and the ALU/multiply-divide unit.

## Interface
- `ALU_OP_WIDTH`, 3: width of the ALU op field from the control unit.
- `FUNCT_WIDTH`, 6: width of the instruction function field.
- `OPER_WIDTH`, 4: width of the ALU operation code; minimum 4.
- `MULT_CYCLES`, 4: busy cycles for MULT; minimum 1.
- `DIV_CYCLES`, 32: busy cycles for DIV; minimum 1.

Ports:
- `clk`, in, 1: the single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `valid_i`, in, 1: the decode-stage instruction is valid.
- `alu_op_i`, in, `ALU_OP_WIDTH`: ALU op from the control unit.
- `alu_function_i`, in, `FUNCT_WIDTH`: instruction funct field.
- `alu_operation_o`, out, `OPER_WIDTH`: ALU operation code (combinational).
- `illegal_o`, out, 1: `valid_i` and the selector matched no entry.
- `md_start_o`, out, 1: one-cycle start pulse to the multiply/divide unit.
- `md_op_o`, out, 1: 0 = MULT, 1 = DIV; held from start until completion.
- `stall_o`, out, 1: hold the PC and decode stage this cycle.
- `hilo_we_o`, out, 1: one-cycle HI/LO write enable.

## Operation
- The selector is `{alu_op_i, alu_function_i}`. I-type entries ignore funct.
- R-type (`alu_op_i`=111), funct to operation code:
  - ADD 0x20 → 0011
  - SUB 0x22 → 0100
  - AND 0x24 → 0000
  - OR 0x25 → 0001
  - SLT 0x2A → 0111
  - SLL 0x00 → 0010
  - SRL 0x02 → 0101
  - MULT 0x18 → 1000
  - DIV 0x1A → 1010
  - MFHI 0x10 → 1011
  - MFLO 0x12 → 1100
- I-type, `alu_op_i` to operation code:
  - ADDI 100 → 0011
  - ORI 001 → 0001
  - LUI 010 → 0110
  - ANDI 011 → 0000
  - SLTI 101 → 0111
- Default → 1001, and `illegal_o`=1 when `valid_i`=1.
- Codes are zero-extended when `OPER_WIDTH` > 4.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `valid_i` and MULT/DIV, assert `md_start_o`, latch `md_op_o`, load the counter with CYCLES-1, then go to BUSY.
  - BUSY: decrement the counter each cycle. At counter==0, go to DONE.
  - DONE: `hilo_we_o`=1, then go to IDLE.
- Counter width is `$clog2(max(MULT_CYCLES, DIV_CYCLES))`, minimum 1. It does not wrap: a load only happens in IDLE.
- `stall_o` = (state != IDLE) & `valid_i` & (MULT | DIV | MFHI | MFLO). Independent instructions proceed while BUSY.
- A stalled MULT/DIV is accepted in the cycle the FSM is back in IDLE. No start pulse is issued while stalled.
- `md_start_o` is never asserted with `stall_o`.
- `illegal_o` never affects the FSM.
- `reset` mid-operation: return to IDLE and clear the counter. No `hilo_we_o` pulse is issued for the aborted operation.

## Timing
- Reset values: state IDLE, counter 0, `md_op_o`=0, `hilo_we_o`=0, `md_start_o`=0, `stall_o`=0.
- Combinational outputs with reset held: `alu_operation_o` follows the inputs; `illegal_o` follows `valid_i` and the decode.
- Decode latency is 0 cycles.
- `md_start_o` is combinational in cycle N, the accept cycle.
- BUSY spans cycles N+1 to N+CYCLES. DONE (`hilo_we_o`=1) is cycle N+CYCLES+1. IDLE resumes at N+CYCLES+2.
- An MFHI/MFLO in the DONE cycle stalls. The same instruction issues in cycle N+CYCLES+2 and sees the updated HI/LO.

## Configuration
- `ALU_CTRL_DIV_EN` defined: DIV decodes to 1010 and is sequenced with `DIV_CYCLES`.
- `ALU_CTRL_DIV_EN` undefined:
  - funct 0x1A falls to default (1001), with `illegal_o` set.
  - No start is issued and `md_op_o` stays 0.
  - `DIV_CYCLES` is ignored for counter sizing.

## Structure
- Package `alu_ctrl_pkg` holds:
  - operation-code constants;
  - R-type funct constants;
  - I-type `alu_op` constants;
  - the FSM state encoding.
- Sub-module `alu_decode`: purely combinational selector → {operation code, illegal, is_md, is_div, is_mf}.
- The top level holds the FSM, the counter, and the stall logic.

## Test plan
- Decode sweep: each table entry with `valid_i`=1 gives the listed code. `alu_op_i`=111 with funct 0x3F gives 1001 and `illegal_o`=1.
- MULT with `MULT_CYCLES`=4, accepted at cycle 0: `md_start_o`@0, BUSY 1–4, `hilo_we_o`@5, IDLE@6. An ADD at cycle 2 is not stalled.
- DIV immediately followed by MFLO: MFLO stalls through the DONE cycle and issues in cycle `DIV_CYCLES`+2. No second start is issued.
- Back-to-back MULT, MULT: the second stalls until IDLE, then `md_start_o` pulses exactly once more.
- `reset` asserted at BUSY cycle 2: IDLE next cycle, no `hilo_we_o` pulse, `md_op_o`=0.
- Build without `ALU_CTRL_DIV_EN`: DIV gives 1001, `illegal_o`=1, no `md_start_o`, no stall.
